bram_loader: RTL and testbench

Byte-stream writer that fills the on-chip RAM BRAM at runtime: accepts bytes on a valid/ready stream (e.g. from a UART boot path), packs them little-endian into 32-bit words, and issues word writes with byte strobes on the native valid/ready memory interface. It sits between the boot/debug byte source and the RAM BRAM's write port. It is the writer counterpart of the byte-serial ROM reader, which unpacks words byte by byte.

---
 rtl/bram_loader_pkg.sv | 22 ++
 rtl/bram_loader_if.sv | 30 +++
 rtl/bram_loader_byte_packer.sv | 38 +++
 rtl/bram_loader.sv | 136 +++++++++++++
 tb/tb_bram_loader.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_loader_pkg.sv
// bram_loader_pkg: shared definitions for the BRAM byte-stream loader.
//   state_t        : loader FSM encoding (IDLE/COLLECT/WRITE/DONE, 2 bits)
//   BYTES_PER_WORD : bytes packed into one 32-bit RAM word
//   LANE_W         : width of a byte-lane index
//   addr_width()   : word-address width for a given RAM depth
package bram_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

  function automatic int unsigned addr_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/bram_loader_if.sv
// bram_loader_if: byte-stream input and RAM write-port handshakes of the loader.
//   in_valid/in_ready/in_data                   : byte stream into the loader
//   mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb : word writes to the RAM
// Modports:
//   master : the loader side (drives in_ready and all mem_* requests)
//   slave  : the environment side (byte source and RAM write port)
interface bram_loader_if
  import bram_loader_pkg::*;
#(
  parameter int unsigned AW = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic [7:0]                    in_data;
  logic                          mem_valid;
  logic                          mem_ready;
  logic [AW-1:0]                 mem_addr;
  logic [8*BYTES_PER_WORD-1:0]   mem_wdata;
  logic [BYTES_PER_WORD-1:0]     mem_wstrb;

  modport master (
    input  in_valid, in_data, mem_ready,
    output in_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output in_valid, in_data, mem_ready,
    input  in_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/bram_loader_byte_packer.sv
// bram_byte_packer: accumulates bytes little-endian into one 32-bit word.
//   clk, reset : clock and synchronous active-high reset
//   clear      : empty the word (lane 0, no strobes, data zero)
//   load       : place data into the current lane and advance the lane
//   data       : byte to place
//   wdata      : packed word, unwritten lanes read as zero
//   strb       : one bit per written lane
//   last_lane  : current lane is the final lane of the word
module bram_byte_packer
  import bram_loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          load,
  input  logic [7:0]                    data,
  output logic [8*BYTES_PER_WORD-1:0]   wdata,
  output logic [BYTES_PER_WORD-1:0]     strb,
  output logic                          last_lane
);

  logic [LANE_W-1:0] lane;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane  <= '0;
      wdata <= '0;
      strb  <= '0;
    end else if (load) begin
      wdata[8*lane +: 8] <= data;
      strb[lane]         <= 1'b1;
      lane               <= lane + LANE_W'(1);
    end
  end

  assign last_lane = (lane == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/bram_loader.sv
// bram_loader: fills the on-chip RAM from a byte stream at runtime.
// Bytes are packed little-endian into 32-bit words and written with byte
// strobes; a short final word carries strobes only for its written lanes.
//   clk, reset  : clock and synchronous active-high reset
//   start       : one-cycle pulse, latches start_addr/len (ignored while busy)
//   start_addr  : first word address
//   len         : byte count of the load (0 is legal)
//   bus         : bram_loader_if.master (byte stream in, RAM write port out)
//   busy        : high from the cycle after start until done
//   done        : one-cycle pulse at end of load
//   checksum    : 32-bit word-sum of the load
// Build option: define BRAM_LOADER_CHECKSUM_EN to accumulate checksum;
// otherwise checksum is tied to zero and no adder is built.
module bram_loader
  import bram_loader_pkg::*;
#(
  parameter  int unsigned WORDS = 256,
  localparam int unsigned AW    = addr_width(WORDS)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic [15:0]      len,
  bram_loader_if.master    bus,
  output logic             busy,
  output logic             done,
  output logic [31:0]      checksum
);

  state_t        state;
  logic [AW-1:0] addr;
  logic [15:0]   remaining;
  logic          mem_valid_q;

  logic          accept;
  logic          write_done;
  logic          start_load;
  logic          pk_last;
  logic [31:0]   pk_wdata;
  logic [3:0]    pk_strb;

  assign start_load = (state == S_IDLE) && start;
  assign accept     = (state == S_COLLECT) && bus.in_valid;
  assign write_done = (state == S_WRITE) && bus.mem_ready;

  bram_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_load || write_done),
    .load      (accept),
    .data      (bus.in_data),
    .wdata     (pk_wdata),
    .strb      (pk_strb),
    .last_lane (pk_last)
  );

  // in_ready decodes state only; every other output is a register.
  assign bus.in_ready  = (state == S_COLLECT);
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = pk_wdata;
  assign bus.mem_wstrb = pk_strb;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      addr        <= '0;
      remaining   <= '0;
      mem_valid_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= start_addr;
            remaining <= len;
            busy      <= 1'b1;
            state     <= (len == 16'd0) ? S_DONE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (bus.in_valid) begin
            remaining <= remaining - 16'd1;
            if (pk_last || remaining == 16'd1) begin
              mem_valid_q <= 1'b1;
              state       <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (bus.mem_ready) begin
            mem_valid_q <= 1'b0;
            addr        <= (addr == AW'(WORDS - 1)) ? '0 : addr + AW'(1);
            if (remaining == 16'd0) begin
              // done is raised on the final handshake so it lands in the
              // cycle right after it, in step with busy falling.
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              state <= S_COLLECT;
            end
          end
        end
        S_DONE: begin
          // Arriving from WRITE, done is already high and now ends. Arriving
          // straight from a zero-length start, done is low and fires now,
          // two cycles after the start pulse.
          done  <= ~done;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef BRAM_LOADER_CHECKSUM_EN
  logic [31:0] sum;

  always_ff @(posedge clk) begin
    if (reset || start_load) begin
      sum <= '0;
    end else if (write_done) begin
      sum <= sum + pk_wdata;
    end
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_bram_loader.sv
module tb_bram_loader;
  localparam int WORDS = 256;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  typedef struct {
    logic [7:0]  sa;
    int          n;
    logic [7:0]  base;
    logic [7:0]  step;
    int          rdy;
    int          vprob;
    bit          dup;
    int          exp_n;
    logic [7:0]  exp_a;
    logic [31:0] exp_d;
    logic [3:0]  exp_s;
    logic [31:0] exp_sum;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  start_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] src [0:63];
  wr_t        exp_q [$];
  vec_t       vec [7];

  bram_loader_if #(.AW(8)) bus ();

  bram_loader #(.WORDS(WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ck(input logic [31:0] s);
`ifdef BRAM_LOADER_CHECKSUM_EN
    return s;
`else
    return 32'h0 & s;
`endif
  endfunction

  // Runs one load using bytes src[0..n-1]; checks every cycle against a
  // word list built directly from the byte sequence.
  task automatic run_load(input logic [7:0] sa, input int n, input int rdy,
                          input int vprob, input bit dup,
                          output int nw, output logic [7:0] last_a,
                          output logic [31:0] last_d, output logic [3:0] last_s);
    wr_t         wr;
    logic [31:0] sum;
    int          idx, wcnt, st_cyc, exp_done, nexp;
    bit          seen_done, expect_mv;

    exp_q.delete();
    sum = '0;
    for (int w = 0; w * 4 < n; w++) begin
      wr.a = 8'((int'(sa) + w) % WORDS);
      wr.d = '0;
      wr.s = '0;
      for (int b = 0; b < 4 && w * 4 + b < n; b++) begin
        wr.d = wr.d | (32'(src[w*4+b]) << (8 * b));
        wr.s[b] = 1'b1;
      end
      exp_q.push_back(wr);
      sum = sum + wr.d;
    end
    nexp = exp_q.size();

    nw = 0; last_a = '0; last_d = '0; last_s = '0;
    idx = 0; wcnt = 0; seen_done = 0; expect_mv = 0;

    @(posedge clk); #1;
    start = 1'b1; start_addr = sa; len = 16'(n);
    bus.in_valid = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    st_cyc = cyc;
    exp_done = (n == 0) ? st_cyc + 2 : -1;
    @(posedge clk); #1;

    for (int t = 0; t < 400 && !seen_done; t++) begin
      start = 1'b0;
      if (dup && t == 2) begin
        start = 1'b1; start_addr = sa + 8'h10; len = 16'(n + 4);
      end
      bus.in_valid  = (idx < n) && ($urandom_range(99) < vprob);
      bus.in_data   = bus.in_valid ? src[idx] : 8'($urandom);
      bus.mem_ready = bus.mem_valid && (wcnt >= rdy);
      @(negedge clk);

      if (expect_mv) begin
        chk("mem_valid_after_word", bus.mem_valid, 1);
        expect_mv = 0;
      end
      if (bus.mem_valid) begin
        chk("in_ready_low_in_write", bus.in_ready, 0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_write actual=addr %h required=no write", bus.mem_addr);
        end else begin
          chk("write_addr", bus.mem_addr, exp_q[0].a);
          chk("write_data", bus.mem_wdata, exp_q[0].d);
          chk("write_strb", bus.mem_wstrb, exp_q[0].s);
        end
        if (bus.mem_ready) begin
          wcnt = 0;
          nw++;
          last_a = bus.mem_addr; last_d = bus.mem_wdata; last_s = bus.mem_wstrb;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          if (nw == nexp) exp_done = cyc + 1;
        end else begin
          wcnt++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        idx++;
        if (idx % 4 == 0 || idx == n) expect_mv = 1;
      end
      if (done) begin
        seen_done = 1;
        chk("done_cycle", cyc, exp_done);
        chk("busy_low_at_done", busy, 0);
      end else begin
        chk("busy_high", busy, 1);
        @(posedge clk); #1;
      end
    end

    if (!seen_done) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=no done required=done within 400 cycles");
    end else begin
      chk("bytes_consumed", idx, n);
      chk("write_count", nw, nexp);
      chk("checksum", checksum, ck(sum));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("done_single_pulse", done, 0);
      chk("idle_mem_valid", bus.mem_valid, 0);
    end
    start = 1'b0; bus.in_valid = 1'b0; bus.mem_ready = 1'b0;
  endtask

  initial begin : main
    int          nw;
    logic [7:0]  la;
    logic [31:0] ld;
    logic [3:0]  ls;
    bit          got_mv;
    int          rn;

    reset = 1'b1; start = 1'b0; start_addr = '0; len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_mem_valid", bus.mem_valid, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_wstrb", bus.mem_wstrb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_checksum", checksum, 0);
    @(posedge clk); #1 reset = 1'b0;

    vec[0] = '{8'h10,  8, 8'h01, 8'h01, 1, 100, 1'b0, 2, 8'h11, 32'h08070605, 4'hF, 32'h0C0A0806};
    vec[1] = '{8'h20,  6, 8'hAA, 8'h11, 1, 100, 1'b0, 2, 8'h21, 32'h0000FFEE, 4'h3, 32'hDDCDBB98};
    vec[2] = '{8'h05,  0, 8'h00, 8'h00, 0, 100, 1'b0, 0, 8'h00, 32'h00000000, 4'h0, 32'h00000000};
    vec[3] = '{8'hFF,  8, 8'h01, 8'h01, 1, 100, 1'b0, 2, 8'h00, 32'h08070605, 4'hF, 32'h0C0A0806};
    vec[4] = '{8'h40,  5, 8'h11, 8'h01, 5,  50, 1'b0, 2, 8'h41, 32'h00000015, 4'h1, 32'h14131226};
    vec[5] = '{8'h03,  1, 8'h7E, 8'h00, 0, 100, 1'b0, 1, 8'h03, 32'h0000007E, 4'h1, 32'h0000007E};
    vec[6] = '{8'h80, 12, 8'hF0, 8'h01, 2,  70, 1'b1, 3, 8'h82, 32'hFBFAF9F8, 4'hF, 32'hE7E4E1DC};

    foreach (vec[i]) begin
      for (int k = 0; k < 64; k++) src[k] = 8'(vec[i].base + vec[i].step * k);
      run_load(vec[i].sa, vec[i].n, vec[i].rdy, vec[i].vprob, vec[i].dup, nw, la, ld, ls);
      chk("vec_nwrites", nw, vec[i].exp_n);
      chk("vec_last_addr", la, vec[i].exp_a);
      chk("vec_last_data", ld, vec[i].exp_d);
      chk("vec_last_strb", ls, vec[i].exp_s);
      chk("vec_checksum", checksum, ck(vec[i].exp_sum));
    end

    // Reset while a write is pending, then a fresh load with a stray start.
    @(posedge clk); #1;
    start = 1'b1; start_addr = 8'h30; len = 16'd4;
    @(posedge clk); #1;
    start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'h5A; bus.mem_ready = 1'b0;
    got_mv = 0;
    for (int t = 0; t < 20 && !got_mv; t++) begin
      @(negedge clk);
      if (bus.mem_valid) got_mv = 1;
      else begin @(posedge clk); #1; end
    end
    if (!got_mv) begin
      checks++; errors++;
      $display("FAIL write_wait_timeout actual=no mem_valid required=mem_valid within 20 cycles");
    end
    @(posedge clk); #1;
    reset = 1'b1; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_mem_valid", bus.mem_valid, 0);
    chk("midrst_mem_addr", bus.mem_addr, 0);
    chk("midrst_mem_wdata", bus.mem_wdata, 0);
    chk("midrst_mem_wstrb", bus.mem_wstrb, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_checksum", checksum, 0);

    for (int k = 0; k < 64; k++) src[k] = 8'(8'h21 + 3 * k);
    run_load(8'h50, 8, 1, 100, 1'b1, nw, la, ld, ls);
    chk("post_reset_nwrites", nw, 2);
    chk("post_reset_last_addr", la, 8'h51);

    // Randomised loads against the word-list model.
    for (int r = 0; r < 20; r++) begin
      rn = int'($urandom_range(20));
      for (int k = 0; k < 64; k++) src[k] = 8'($urandom);
      run_load(8'($urandom), rn, int'($urandom_range(3)), int'($urandom_range(100, 30)),
               (rn >= 4) && ($urandom_range(1) == 1), nw, la, ld, ls);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
